// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if - bundle between the pipeline datapath and its hazard/halt controller.
//   Datapath -> controller: ID source regs, EX destination/load/branch/halt, dm_busy, resume.
//   Controller -> datapath: PC and stage-register enables, bubble clears, halted, state.
//   PIPE_CTRL_PERF_EN: adds the stall_cnt / flush_cnt performance counters.
// Modports: slave = controller side, master = datapath (or testbench) side.
interface pipe_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  ex_rw;
    logic        ex_is_load;
    logic        ex_branch_taken;
    logic        ex_halt;
    logic        dm_busy;
    logic        resume;
    logic        pc_en;
    logic        ps1_en;
    logic        ps2_en;
    logic        ps3_en;
    logic        ps4_en;
    logic        ps1_clr;
    logic        ps2_clr;
    logic        halted;
    logic [1:0]  state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rw, ex_is_load, ex_branch_taken,
               ex_halt, dm_busy, resume,
`ifdef PIPE_CTRL_PERF_EN
        output stall_cnt, flush_cnt,
`endif
        output pc_en, ps1_en, ps2_en, ps3_en, ps4_en, ps1_clr, ps2_clr,
               halted, state
    );

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rw, ex_is_load, ex_branch_taken,
               ex_halt, dm_busy, resume,
`ifdef PIPE_CTRL_PERF_EN
        input  stall_cnt, flush_cnt,
`endif
        input  pc_en, ps1_en, ps2_en, ps3_en, ps4_en, ps1_clr, ps2_clr,
               halted, state
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - 5-stage pipeline hazard / halt controller.
//   clk : rising-edge clock for all state
//   rst : asynchronous active-high reset
//   bus : pipe_ctrl_if.slave (ID/EX hazard inputs, dm_busy, resume in;
//         PC/stage enables, bubble clears, halted, state out)
// FSM RUN -> DRAIN (2 non-busy cycles to retire older instructions) -> HALT -> RUN on resume.
// Outputs are combinational from state and inputs; all of them are forced low while rst is high.
// Optional build macro PIPE_CTRL_PERF_EN: adds 32-bit stall_cnt / flush_cnt counters.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic pc_en, ps1_en, ps2_en, ps3_en, ps4_en, ps1_clr, ps2_clr, halted;
    logic load_use;
    logic flush_act;

    // r0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = bus.ex_is_load && (bus.ex_rw != 5'd0) &&
                      ((bus.ex_rw == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rw == bus.id_rt)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_en     = 1'b0;
        ps1_en    = 1'b0;
        ps2_en    = 1'b0;
        ps3_en    = 1'b0;
        ps4_en    = 1'b0;
        ps1_clr   = 1'b0;
        ps2_clr   = 1'b0;
        halted    = 1'b0;
        flush_act = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.dm_busy) begin
                        // Full freeze; hazards are re-evaluated once memory is done.
                    end else if (bus.ex_halt) begin
                        // Stop fetching; older instructions keep draining.
                        state_d = ST_DRAIN;
                        cnt_d   = 2'd2;
                        ps2_en  = 1'b1;
                        ps3_en  = 1'b1;
                        ps4_en  = 1'b1;
                        ps2_clr = 1'b1;
                    end else if (bus.ex_branch_taken) begin
                        // Squash the two wrong-path instructions; wins over load-use.
                        pc_en     = 1'b1;
                        ps1_en    = 1'b1;
                        ps2_en    = 1'b1;
                        ps3_en    = 1'b1;
                        ps4_en    = 1'b1;
                        ps1_clr   = 1'b1;
                        ps2_clr   = 1'b1;
                        flush_act = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, inject one bubble into ID/EX.
                        ps2_en  = 1'b1;
                        ps3_en  = 1'b1;
                        ps4_en  = 1'b1;
                        ps2_clr = 1'b1;
                    end else begin
                        pc_en  = 1'b1;
                        ps1_en = 1'b1;
                        ps2_en = 1'b1;
                        ps3_en = 1'b1;
                        ps4_en = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.dm_busy) begin
                        ps2_en  = 1'b1;
                        ps3_en  = 1'b1;
                        ps4_en  = 1'b1;
                        ps2_clr = 1'b1;
                        if (cnt_q <= 2'd1) begin
                            cnt_d   = 2'd0;
                            state_d = ST_HALT;
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (bus.resume) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_en   = pc_en;
    assign bus.ps1_en  = ps1_en;
    assign bus.ps2_en  = ps2_en;
    assign bus.ps3_en  = ps3_en;
    assign bus.ps4_en  = ps4_en;
    assign bus.ps1_clr = ps1_clr;
    assign bus.ps2_clr = ps2_clr;
    assign bus.halted  = halted;
    assign bus.state   = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == ST_RUN) && !pc_en) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_act)                     flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl - directed self-checking bench for pipe_ctrl.
// Output vector order: {pc_en, ps1_en, ps2_en, ps3_en, ps4_en, ps1_clr, ps2_clr, halted, state[1:0]}.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pipe_ctrl_if bus();
    pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [9:0] outv;
    assign outv = {bus.pc_en, bus.ps1_en, bus.ps2_en, bus.ps3_en, bus.ps4_en,
                   bus.ps1_clr, bus.ps2_clr, bus.halted, bus.state};

    localparam logic [9:0] V_ZERO   = 10'b00000_00_0_00;
    localparam logic [9:0] V_NORM   = 10'b11111_00_0_00;
    localparam logic [9:0] V_LU     = 10'b00111_01_0_00;
    localparam logic [9:0] V_BR     = 10'b11111_11_0_00;
    localparam logic [9:0] V_FRZ    = 10'b00000_00_0_00;
    localparam logic [9:0] V_DRAIN  = 10'b00111_01_0_01;
    localparam logic [9:0] V_DRFRZ  = 10'b00000_00_0_01;
    localparam logic [9:0] V_HALT   = 10'b00000_00_1_10;

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic [4:0] rw, input logic ld, input logic br,
                          input logic hlt, input logic busy, input logic res);
        bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = urt; bus.ex_rw = rw;
        bus.ex_is_load = ld; bus.ex_branch_taken = br; bus.ex_halt = hlt;
        bus.dm_busy = busy; bus.resume = res;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if (outv !== V_ZERO) begin
            failures++; $display("FAIL reset_outputs got=%b exp=%b", outv, V_ZERO);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
            failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt);
        end
`endif
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL after_reset got=%b exp=%b", outv, V_NORM);
        end
    endtask

    task automatic test_load_use();
`ifdef PIPE_CTRL_PERF_EN
        logic [31:0] s0;
`endif
        // lw r5 in EX, ID reads rs=5 -> single bubble
        @(negedge clk); set_in(5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_LU) begin
            failures++; $display("FAIL lu_rs got=%b exp=%b", outv, V_LU);
        end
`ifdef PIPE_CTRL_PERF_EN
        s0 = bus.stall_cnt;
`endif
        // bubble now in EX
        @(negedge clk); set_in(5'd5, 5'd7, 1'b1, 5'd0, 1'b0, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL lu_after_bubble got=%b exp=%b", outv, V_NORM);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.stall_cnt !== s0 + 32'd1) begin
            failures++; $display("FAIL stall_cnt_inc got=%0d exp=%0d", bus.stall_cnt, s0 + 32'd1);
        end
`endif
        // rt match only counts when rt is read
        @(negedge clk); set_in(5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_LU) begin
            failures++; $display("FAIL lu_rt got=%b exp=%b", outv, V_LU);
        end
        @(negedge clk); set_in(5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL lu_rt_unused got=%b exp=%b", outv, V_NORM);
        end
        // load to r0 never stalls
        @(negedge clk); set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL lu_r0 got=%b exp=%b", outv, V_NORM);
        end
        // non-load to r5 does not stall
        @(negedge clk); set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL lu_not_load got=%b exp=%b", outv, V_NORM);
        end
    endtask

    task automatic test_branch();
`ifdef PIPE_CTRL_PERF_EN
        logic [31:0] f0;
`endif
        @(negedge clk); set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1, 0, 0, 0); #1;
        checks++;
        if (outv !== V_BR) begin
            failures++; $display("FAIL branch_over_lu got=%b exp=%b", outv, V_BR);
        end
`ifdef PIPE_CTRL_PERF_EN
        f0 = bus.flush_cnt;
`endif
        @(negedge clk); set_in(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL branch_after got=%b exp=%b", outv, V_NORM);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.flush_cnt !== f0 + 32'd1) begin
            failures++; $display("FAIL flush_cnt_inc got=%0d exp=%0d", bus.flush_cnt, f0 + 32'd1);
        end
`endif
    endtask

    task automatic test_busy();
        // busy overrides branch
        @(negedge clk); set_in(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1, 0, 1, 0); #1;
        checks++;
        if (outv !== V_FRZ) begin
            failures++; $display("FAIL busy_over_branch got=%b exp=%b", outv, V_FRZ);
        end
        // load-use held under 3 busy cycles, then one bubble
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_in(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 0, 0, 1, 0); #1;
            checks++;
            if (outv !== V_FRZ) begin
                failures++; $display("FAIL busy_freeze_%0d got=%b exp=%b", i, outv, V_FRZ);
            end
        end
        @(negedge clk); set_in(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_LU) begin
            failures++; $display("FAIL busy_then_bubble got=%b exp=%b", outv, V_LU);
        end
        @(negedge clk); set_in(5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL busy_resume_flow got=%b exp=%b", outv, V_NORM);
        end
    endtask

    task automatic test_halt();
        // resume outside HALT is ignored
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL resume_in_run got=%b exp=%b", outv, V_NORM);
        end
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
        checks++;
        if (outv !== V_LU) begin
            failures++; $display("FAIL halt_entry got=%b exp=%b", outv, V_LU);
        end
        // busy in DRAIN freezes and holds the counter
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        checks++;
        if (outv !== V_DRFRZ) begin
            failures++; $display("FAIL drain_busy got=%b exp=%b", outv, V_DRFRZ);
        end
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_DRAIN) begin
            failures++; $display("FAIL drain_1 got=%b exp=%b", outv, V_DRAIN);
        end
        // branch ignored in DRAIN
        @(negedge clk); set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); #1;
        checks++;
        if (outv !== V_DRAIN) begin
            failures++; $display("FAIL drain_2 got=%b exp=%b", outv, V_DRAIN);
        end
        // halt ignored in HALT
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
        checks++;
        if (outv !== V_HALT) begin
            failures++; $display("FAIL halted got=%b exp=%b", outv, V_HALT);
        end
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        checks++;
        if (outv !== V_HALT) begin
            failures++; $display("FAIL halt_resume_cycle got=%b exp=%b", outv, V_HALT);
        end
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL run_after_resume got=%b exp=%b", outv, V_NORM);
        end
    endtask

    task automatic test_rst_in_drain();
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++;
        if (outv !== V_DRAIN) begin
            failures++; $display("FAIL rst_pre_drain got=%b exp=%b", outv, V_DRAIN);
        end
        #1 rst = 1'b1; #1;
        checks++;
        if (outv !== V_ZERO) begin
            failures++; $display("FAIL rst_in_drain got=%b exp=%b", outv, V_ZERO);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
            failures++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt);
        end
`endif
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL rst_release got=%b exp=%b", outv, V_NORM);
        end
        @(negedge clk); #1;
        checks++;
        if (outv !== V_NORM) begin
            failures++; $display("FAIL rst_release_next got=%b exp=%b", outv, V_NORM);
        end
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_branch();
        test_busy();
        test_halt();
        test_rst_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have ports: id_uses_rt  in  1  ID instruction reads rt.
REQ-005 SHALL have ports: ex_rw  in  5  EX destination register number.
REQ-006 SHALL have ports: ex_is_load  in  1  EX instruction is a load.
REQ-007 SHALL have ports: ex_branch_taken  in  1  EX resolved branch/jump taken.
REQ-008 SHALL have ports: ex_halt  in  1  EX syscall requests halt.
REQ-009 SHALL have ports: dm_busy  in  1  data memory multi-cycle access pending.
REQ-010 SHALL have ports: resume  in  1  single-cycle resume pulse.
REQ-011 SHALL have ports: pc_en, ps1_en, ps2_en, ps3_en, ps4_en  out  1 each  PC and stage-register enables.
REQ-012 SHALL have ports: ps1_clr, ps2_clr  out  1 each  synchronous bubble insert into IF/ID and ID/EX.
REQ-013 SHALL have ports: halted  out  1  high while in HALT.
REQ-014 SHALL have ports: state  out  2  FSM state (RUN=0, DRAIN=1, HALT=2).

Function
REQ-015 SHALL implement FSM RUN/DRAIN/HALT with a 2-bit drain counter.
REQ-016 SHALL, in RUN with no event, assert all enables and deassert both clears.
REQ-017 SHALL detect load-use when ex_is_load and ex_rw!=0 and (ex_rw==id_rs or (id_uses_rt and ex_rw==id_rt)).
REQ-018 SHALL, on load-use: pc_en=0, ps1_en=0, ps2_clr=1; exactly one bubble per hazard.
REQ-019 SHALL, on ex_branch_taken: ps1_clr=1, ps2_clr=1, pc_en=1; a taken branch overrides a load-use hazard in the same cycle.
REQ-020 SHALL, while dm_busy: deassert all enables and clears (full freeze); dm_busy overrides branch and load-use, which are re-evaluated once it drops.
REQ-021 SHALL, on ex_halt in RUN without dm_busy: go to DRAIN, load counter with 2, pc_en=0, ps1_en=0, ps2_clr=1.
REQ-022 SHALL, in DRAIN: pc_en=0, ps1_en=0, ps2_clr=1, ps3_en=ps4_en=1, decrement counter per non-busy cycle, go to HALT when counter reaches 0.
REQ-023 SHALL, in HALT: all enables 0, clears 0, halted=1; resume moves to RUN next cycle, and resume outside HALT is ignored.
REQ-024 SHALL generate outputs combinationally from state and inputs; state changes only on clk rising edge.
REQ-025 SHALL ignore ex_branch_taken and ex_halt outside RUN.

Reset
REQ-026 SHALL, while rst is high: state=RUN, counter=0, all enables 0, clears 0, halted=0.
REQ-027 SHALL, on rst asserted mid-DRAIN or in HALT, abandon the drain immediately; the first cycle after release is RUN.

Configuration
REQ-028 SHALL, with PIPE_CTRL_PERF_EN defined, add outputs stall_cnt and flush_cnt (32-bit, out): cycles with pc_en=0 in RUN, and cycles with ex_branch_taken acted upon; both wrap modulo 2^32 and reset to 0.
REQ-029 SHALL, without PIPE_CTRL_PERF_EN, omit both ports and counters with no other behavioural change.

Verification
REQ-030 SHALL cover: lw to r5 in EX, ID reads rs=5 -> one cycle pc_en=0, ps2_clr=1, then normal flow; same with ex_rw=0 -> no stall.
REQ-031 SHALL cover: ex_branch_taken and load-use in the same cycle -> ps1_clr=ps2_clr=1, pc_en=1.
REQ-032 SHALL cover: ex_halt -> DRAIN 2 cycles -> HALT with halted=1; resume pulse -> RUN next cycle.
REQ-033 SHALL cover: dm_busy held 3 cycles during a load-use -> 3 freeze cycles, then the single bubble.
REQ-034 SHALL cover: rst pulse in DRAIN -> state=0 and outputs at reset values; with PIPE_CTRL_PERF_EN, stall_cnt=flush_cnt=0.
